// File: rtl/contador_prog.sv
// Programmable modulo-MOD counter with free-run and one-shot modes, load and terminal-count pulse.
// Down-counting is compiled in only when CONTADOR_PROG_DOWN_EN is defined.
module contador_prog #(
  parameter int unsigned N   = 8,
  parameter int unsigned MOD = 200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         mode,
  input  logic         start,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  localparam logic [N-1:0] Top = N'(MOD - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic         down;
  logic         at_term;
  logic [N-1:0] stepped;

`ifdef CONTADOR_PROG_DOWN_EN
  assign down = dir;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign down       = 1'b0;
`endif

  always_comb begin
    at_term = down ? (count_q == '0) : (count_q == Top);
    if (down) begin
      stepped = (count_q == '0) ? Top : count_q - N'(1);
    end else begin
      stepped = (count_q == Top) ? '0 : count_q + N'(1);
    end
  end

  // Priority: load, then start, then the per-state count step.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (load_val > Top) ? Top : load_val;
      state_d = StIdle;
    end else if (start && mode && (state_q == StIdle)) begin
      count_d = down ? Top : '0;
      state_d = StRun;
    end else begin
      case (state_q)
        StIdle: begin
          if (!mode && en) begin
            count_d = stepped;
            tc_d    = at_term;
          end
        end
        StRun: begin
          // Leaving one-shot mode mid-run drops back to idle without a step.
          if (!mode) begin
            state_d = StIdle;
          end else if (en) begin
            if (at_term) begin
              state_d = StDone;
              tc_d    = 1'b1;
            end else begin
              count_d = stepped;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);

endmodule

// File: tb/tb_contador_prog.sv
// Scoreboard bench for contador_prog at N=4, MOD=10; expectations are queued as stimulus is driven.
module tb_contador_prog;

  localparam int unsigned N   = 4;
  localparam int unsigned MOD = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         dir = 1'b0;
  logic         mode = 1'b0;
  logic         start = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] count;
  logic         tc, busy, done;

  typedef struct packed {
    logic [N-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;
  } obs_t;

  obs_t exp_q[$];
  obs_t got, want;
  int   checks = 0;
  int   errors = 0;

  contador_prog #(.N(N), .MOD(MOD)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .start    (start),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input int c, input bit t, input bit b, input bit d);
    mk = '{count: N'(c), tc: t, busy: b, done: d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    exp_q.push_back(mk(0, 0, 0, 0));
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_hold: got %p want %p", got, want); end
    tick();
    reset = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0));
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_release: got %p want %p", got, want); end
  endtask

  task automatic test_free_up;
    mode = 1'b0; dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(mk((i + 1) % MOD, ((i + 1) % MOD) == 0, 0, 0));
      tick();
      got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL free_up[%0d]: got %p want %p", i, got, want); end
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(2, 0, 0, 0));
      tick();
      got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL free_hold[%0d]: got %p want %p", i, got, want); end
    end
  endtask

  task automatic test_free_down;
    load = 1'b1; load_val = 4'd0;
    exp_q.push_back(mk(0, 0, 0, 0));
    tick();
    load = 1'b0; dir = 1'b1; en = 1'b1;
`ifdef CONTADOR_PROG_DOWN_EN
    exp_q.push_back(mk(9, 1, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 0));
`else
    exp_q.push_back(mk(1, 0, 0, 0));
    exp_q.push_back(mk(2, 0, 0, 0));
`endif
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL down_load0: got %p want %p", got, want); end
    tick();
    dir = 1'b0;
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL down_step: got %p want %p", got, want); end
    tick();
    en = 1'b0;
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL dir_change: got %p want %p", got, want); end
  endtask

  task automatic test_load;
    int vals[4] = '{13, 15, 10, 7};
    int outs[4] = '{9, 9, 9, 7};
    en = 1'b0; mode = 1'b0; load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_val = N'(vals[i]);
      exp_q.push_back(mk(outs[i], 0, 0, 0));
      tick();
      got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL load[%0d]: got %p want %p", vals[i], got, want); end
    end
    mode = 1'b1; start = 1'b1; load_val = 4'd3;
    exp_q.push_back(mk(3, 0, 0, 0));
    tick();
    load = 1'b0; start = 1'b0; mode = 1'b0;
    exp_q.push_back(mk(3, 0, 0, 0));
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL load_start: got %p want %p", got, want); end
    tick();
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL load_start_idle: got %p want %p", got, want); end
    // Load during a run aborts it.
    mode = 1'b1; start = 1'b1;
    exp_q.push_back(mk(0, 0, 1, 0));
    tick();
    start = 1'b0; load = 1'b1; load_val = 4'd6; en = 1'b1;
    exp_q.push_back(mk(6, 0, 0, 0));
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL run_start: got %p want %p", got, want); end
    tick();
    load = 1'b0; en = 1'b0; mode = 1'b0;
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL load_abort: got %p want %p", got, want); end
  endtask

  task automatic test_oneshot;
    mode = 1'b1; dir = 1'b0; en = 1'b0; start = 1'b1;
    exp_q.push_back(mk(0, 0, 1, 0));
    tick();
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL shot_start: got %p want %p", got, want); end
    start = 1'b0; en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i < 10) exp_q.push_back(mk(i, 0, 1, 0));
      else        exp_q.push_back(mk(9, 1, 0, 1));
      tick();
      got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL shot_step[%0d]: got %p want %p", i, got, want); end
    end
    en = 1'b0;
    exp_q.push_back(mk(9, 0, 0, 0));
    tick();
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL shot_idle: got %p want %p", got, want); end
    mode = 1'b0;
  endtask

  task automatic test_en_toggle;
    mode = 1'b1; dir = 1'b0; en = 1'b0; start = 1'b1;
    exp_q.push_back(mk(0, 0, 1, 0));
    tick();
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL toggle_start: got %p want %p", got, want); end
    // start stays high throughout the run and must not restart it.
    for (int k = 0; k < 6; k++) begin
      en = (k % 2) == 0;
      exp_q.push_back(mk(k / 2 + 1, 0, 1, 0));
      tick();
      got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL toggle[%0d]: got %p want %p", k, got, want); end
    end
    start = 1'b0; mode = 1'b0; en = 1'b1;
    exp_q.push_back(mk(3, 0, 0, 0));
    tick();
    en = 1'b0;
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL mode_drop: got %p want %p", got, want); end
  endtask

  task automatic test_reset_midrun;
    mode = 1'b1; dir = 1'b0; start = 1'b1; en = 1'b0;
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0;
    exp_q.push_back(mk(0, 0, 1, 0));
    tick();
    start = 1'b0; en = 1'b1;
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL mid_start: got %p want %p", got, want); end
    tick();
    tick();
    exp_q.push_back(mk(2, 0, 1, 0));
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL mid_run: got %p want %p", got, want); end
    #3 reset = 1'b1;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0));
    got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
    if (got !== want) begin errors++; $display("FAIL mid_reset_async: got %p want %p", got, want); end
    tick();
    en = 1'b0; mode = 1'b0;
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(0, 0, 0, 0));
      tick();
      got = {count, tc, busy, done}; want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL mid_after[%0d]: got %p want %p", i, got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_free_up();
    test_free_down();
    test_load();
    test_oneshot();
    test_en_toggle();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_prog.md
CONTADOR_PROG -- requirements
Module: contador_prog

Interface
REQ-001 SHALL have parameter N, default 8, meaning count register width in bits (N >= 2).
REQ-002 SHALL have parameter MOD, default 200, meaning count modulus (2 <= MOD <= 2**N).
REQ-003 SHALL have port clk, input, 1 bit, rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port en, input, 1 bit, count enable; one step per clk cycle with en=1.
REQ-006 SHALL have port dir, input, 1 bit, count direction: 0 = up, 1 = down.
REQ-007 SHALL have port mode, input, 1 bit, operating mode: 0 = free-run, 1 = one-shot.
REQ-008 SHALL have port start, input, 1 bit, one-shot trigger.
REQ-009 SHALL have port load, input, 1 bit, synchronous load strobe.
REQ-010 SHALL have port load_val, input, N bits, value written by load.
REQ-011 SHALL have port count, output, N bits, registered current count.
REQ-012 SHALL have port tc, output, 1 bit, registered terminal-count pulse.
REQ-013 SHALL have port busy, output, 1 bit, high while the FSM is in RUN.
REQ-014 SHALL have port done, output, 1 bit, registered one-shot completion pulse.

Function
REQ-015 SHALL define the terminal value as MOD-1 when counting up and 0 when counting down.
REQ-016 SHALL apply per-cycle priority: reset, then load, then start, then count step.
REQ-017 SHALL, on load, set count to load_val, or to MOD-1 if load_val >= MOD, and force the FSM to IDLE, aborting any run.
REQ-018 SHALL, in free-run mode, keep the FSM in IDLE and step count on every cycle with en=1.
REQ-019 SHALL, in free-run mode, wrap up-counting from MOD-1 to 0 and down-counting from 0 to MOD-1.
REQ-020 SHALL hold count unchanged on any cycle with en=0 and no load or start.
REQ-021 SHALL implement one-shot mode with states IDLE, RUN and DONE.
REQ-022 SHALL, on start in IDLE with mode=1, preload count with 0 (up) or MOD-1 (down) and enter RUN on the next cycle.
REQ-023 SHALL, in RUN, step count on cycles with en=1 and ignore start.
REQ-024 SHALL, in RUN, on an enabled step taken from the terminal value, hold count at the terminal value and enter DONE.
REQ-025 SHALL stay in DONE for exactly one cycle, then return to IDLE.
REQ-026 SHALL ignore start when mode=0, or when the FSM is in RUN or DONE.
REQ-027 SHALL, when mode changes to 0 during RUN, return the FSM to IDLE on the next edge with count retained.
REQ-028 SHALL assert tc for exactly one cycle, the cycle after any enabled step taken from the terminal value, in either mode.
REQ-029 SHALL assert done for exactly the one cycle the FSM spends in DONE.
REQ-030 SHALL assert busy exactly while the FSM is in RUN.
REQ-031 SHALL sample dir on every step, so that a direction change takes effect on the next enabled step.

Reset
REQ-032 SHALL, on reset assertion, immediately force count=0, tc=0, done=0, busy=0 and FSM=IDLE, independent of clk.
REQ-033 SHALL, on reset asserted mid-run, abort the run with no done or tc pulse.
REQ-034 SHALL begin normal operation on the first rising clk edge after reset deasserts.

Configuration
REQ-035 SHALL compile down-counting support in or out with the macro CONTADOR_PROG_DOWN_EN.
REQ-036 SHALL, with CONTADOR_PROG_DOWN_EN defined, honour dir as specified above.
REQ-037 SHALL, without CONTADOR_PROG_DOWN_EN defined, keep the dir port, ignore it, and always count up.

Verification (N=4, MOD=10)
REQ-038 SHALL verify: free-run, dir=0, en=1 for 12 cycles from reset -> count 1..9,0,1,2; tc high one cycle, when count=0.
REQ-039 SHALL verify: free-run, dir=1, en=1 from count=0 -> count 9 next cycle, tc pulse; (undefined macro) -> count 1, no tc.
REQ-040 SHALL verify: load with load_val=13 -> count=9; load and start in the same cycle -> count=load_val, FSM IDLE.
REQ-041 SHALL verify: mode=1, start, then en=1 for 10 steps -> busy 10 cycles, count holds 9, done and tc one cycle each, then IDLE.
REQ-042 SHALL verify: mode=1, en toggled 1/0 during RUN -> count advances only on en=1 cycles; start during RUN has no effect.
REQ-043 SHALL verify: reset asserted mid-RUN between clock edges -> outputs zero immediately, no done pulse after release.
